// File: rtl/truth_table_checker.sv
// Sweeps every row of two 2**N-entry truth tables, streams each row over valid/ready,
// and reports equivalence, first mismatching row, mismatch count and minterm count of A.
module truth_table_checker #(
   parameter int N = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2**N-1:0] tt_a,
   input  logic [2**N-1:0] tt_b,
   input  logic            row_ready,
   output logic            busy,
   output logic            row_valid,
   output logic [N-1:0]    row_idx,
   output logic            row_a,
   output logic            row_b,
   output logic            row_miss,
   output logic            done,
   output logic            equal,
   output logic [N-1:0]    first_miss,
   output logic [N:0]      miss_cnt,
   output logic [N:0]      ones_a,
   output logic [1:0]      state_dbg
);

   // Handshake: a row moves when row_valid & row_ready are both high at a rising edge;
   // while row_valid is high and row_ready is low, row_idx/row_a/row_b/row_miss hold.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

   logic [1:0]      state;
   logic [2**N-1:0] ta_q;
   logic [2**N-1:0] tb_q;
   logic [N-1:0]    idx;
   logic            in_run;
   logic            transfer;

   assign in_run    = (state == S_RUN);
   assign busy      = in_run;
   assign row_valid = in_run;
   assign done      = (state == S_DONE);
   assign row_idx   = idx;
   assign row_a     = in_run & ta_q[idx];
   assign row_b     = in_run & tb_q[idx];
   assign row_miss  = row_a ^ row_b;
   assign transfer  = row_valid & row_ready;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ta_q       <= '0;
         tb_q       <= '0;
         idx        <= '0;
         equal      <= 1'b0;
         first_miss <= '0;
         miss_cnt   <= '0;
         ones_a     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_RUN;
                  ta_q       <= tt_a;
                  tb_q       <= tt_b;
                  idx        <= '0;
                  equal      <= 1'b0;
                  first_miss <= '0;
                  miss_cnt   <= '0;
                  ones_a     <= '0;
               end
            end
            S_RUN: begin
               if (transfer) begin
                  miss_cnt <= miss_cnt + {{N{1'b0}}, row_miss};
                  ones_a   <= ones_a + {{N{1'b0}}, row_a};
                  // No earlier miss in this sweep means this one is the first.
                  if (row_miss && (miss_cnt == '0)) begin
                     first_miss <= idx;
                  end
                  // Last row: idx stays put so row_idx keeps its final value.
                  if (idx == LAST_IDX) begin
                     state <= S_DONE;
                     equal <= (miss_cnt == '0) && !row_miss;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: directed cases plus random tables and
// random back-pressure, checked against a loop-based reference model.
module tb_truth_table_checker;

   localparam int N = 3;
   localparam int R = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         row_ready = 1'b0;
   logic [R-1:0] tt_a = '0;
   logic [R-1:0] tt_b = '0;
   logic         busy, row_valid, row_a, row_b, row_miss, done, equal;
   logic [N-1:0] row_idx, first_miss;
   logic [N:0]   miss_cnt, ones_a;
   logic [1:0]   state_dbg;

   logic         start1 = 1'b0;
   logic         ready1 = 1'b0;
   logic [1:0]   tt_a1 = '0;
   logic [1:0]   tt_b1 = '0;
   logic         busy1, row_valid1, row_a1, row_b1, row_miss1, done1, equal1;
   logic [0:0]   row_idx1, first_miss1;
   logic [1:0]   miss_cnt1, ones_a1, state_dbg1;

   int tests = 0;
   int fails = 0;

   truth_table_checker #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tt_a(tt_a), .tt_b(tt_b),
      .row_ready(row_ready), .busy(busy), .row_valid(row_valid), .row_idx(row_idx),
      .row_a(row_a), .row_b(row_b), .row_miss(row_miss), .done(done), .equal(equal),
      .first_miss(first_miss), .miss_cnt(miss_cnt), .ones_a(ones_a), .state_dbg(state_dbg)
   );

   truth_table_checker #(.N(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .tt_a(tt_a1), .tt_b(tt_b1),
      .row_ready(ready1), .busy(busy1), .row_valid(row_valid1), .row_idx(row_idx1),
      .row_a(row_a1), .row_b(row_b1), .row_miss(row_miss1), .done(done1), .equal(equal1),
      .first_miss(first_miss1), .miss_cnt(miss_cnt1), .ones_a(ones_a1), .state_dbg(state_dbg1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk every row of the two tables.
   function automatic void model(input logic [R-1:0] ta, input logic [R-1:0] tbv,
                                 output int eq, output int fm, output int mc, output int oa);
      mc = 0;
      oa = 0;
      fm = -1;
      for (int i = 0; i < R; i++) begin
         if (ta[i]) oa++;
         if (ta[i] != tbv[i]) begin
            mc++;
            if (fm < 0) fm = i;
         end
      end
      eq = (mc == 0) ? 1 : 0;
      if (fm < 0) fm = 0;
   endfunction

   // mode 0: ready always, 1: stall on alternate cycles, 2: random ready,
   // 3: ready always with a start re-pulse and tt_a change mid-sweep.
   task automatic run_sweep(input logic [R-1:0] ta, input logic [R-1:0] tbv,
                            input int mode, input int exp_done);
      int  eq, fm, mc, oa, cyc, exp_idx, rows;
      bit  rdy, got_done;
      model(ta, tbv, eq, fm, mc, oa);
      tt_a = ta;
      tt_b = tbv;
      start = 1'b1;
      tick;
      start = 1'b0;
      cyc = 1;
      exp_idx = 0;
      rows = 0;
      got_done = 1'b0;
      while (!got_done && cyc < 200) begin
         if (row_valid) begin
            check("row_idx", row_idx, exp_idx);
            check("row_a", row_a, ta[exp_idx]);
            check("row_b", row_b, tbv[exp_idx]);
            check("row_miss", row_miss, ta[exp_idx] ^ tbv[exp_idx]);
            check("busy_run", busy, 1);
            case (mode)
               1:       rdy = rows[0];
               2:       rdy = ($urandom_range(0, 3) != 0);
               default: rdy = 1'b1;
            endcase
            if (mode == 3 && exp_idx == 3) begin
               start = 1'b1;
               tt_a = ~ta;
            end else begin
               start = 1'b0;
            end
            row_ready = rdy;
            tick;
            cyc++;
            rows++;
            if (rdy) exp_idx++;
         end else if (done) begin
            got_done = 1'b1;
            check("done_cycle", cyc, (exp_done == 0) ? rows + 1 : exp_done);
            check("rows_accepted", exp_idx, R);
            check("done_busy", busy, 0);
            check("miss_cnt", miss_cnt, mc);
            check("ones_a", ones_a, oa);
            check("first_miss", first_miss, fm);
            start = 1'b0;
            row_ready = 1'b0;
            tick;
            check("done_one_cycle", done, 0);
            check("idle_valid", row_valid, 0);
            check("equal", equal, eq);
            check("miss_cnt_hold", miss_cnt, mc);
         end else begin
            check("sweep_gap", done, 1);
            break;
         end
      end
      if (!got_done && cyc >= 200) check("done_timeout", done, 1);
   endtask

   initial begin
      tick;
      tick;
      check("reset_all_zero",
            {busy, row_valid, row_idx, row_a, row_b, row_miss, done, equal,
             first_miss, miss_cnt, ones_a, state_dbg}, 0);
      check("reset_n1_zero",
            {busy1, row_valid1, row_idx1, row_a1, row_b1, row_miss1, done1, equal1,
             first_miss1, miss_cnt1, ones_a1}, 0);
      rst_n = 1'b1;
      tick;

      // Equivalent tables, mismatches at rows 0 and 7, alternate stalls, mid-run disturbance.
      run_sweep(8'hC7, 8'hC7, 0, 9);
      run_sweep(8'hC7, 8'h46, 0, 9);
      run_sweep(8'hC7, 8'hC7, 1, 17);
      run_sweep(8'hC7, 8'h5A, 3, 9);
      run_sweep(8'hFF, 8'h00, 0, 9);
      run_sweep(8'h00, 8'h00, 2, 0);

      // Reset in the middle of a sweep.
      tt_a = 8'hC7;
      tt_b = 8'h46;
      row_ready = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (row_valid && row_idx == 3'd4) break;
         tick;
      end
      check("reached_idx4", row_idx, 4);
      rst_n = 1'b0;
      #1;
      check("midreset_zero",
            {busy, row_valid, row_idx, row_a, row_b, row_miss, done, equal,
             first_miss, miss_cnt, ones_a, state_dbg}, 0);
      tick;
      check("midreset_no_done", done, 0);
      rst_n = 1'b1;
      tick;
      check("after_reset_no_done", done, 0);
      run_sweep(8'hC7, 8'h46, 0, 9);

      // Start held high restarts on every return to IDLE.
      tt_a = 8'hC7;
      tt_b = 8'hC7;
      row_ready = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (done) break;
      end
      check("held_done", done, 1);
      tick;
      check("held_idle_gap", row_valid, 0);
      tick;
      check("held_restart_valid", row_valid, 1);
      check("held_restart_idx", row_idx, 0);
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (done) break;
      end
      check("held_second_done", done, 1);
      tick;

      // Random tables with random back-pressure.
      for (int k = 0; k < 10; k++) begin
         run_sweep(R'($urandom), R'($urandom), 2, 0);
      end

      // N=1 instance.
      tt_a1 = 2'b10;
      tt_b1 = 2'b01;
      ready1 = 1'b1;
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      check("n1_row0", {row_valid1, row_idx1, row_a1, row_b1, row_miss1}, 5'b10011);
      tick;
      check("n1_row1", {row_valid1, row_idx1, row_a1, row_b1, row_miss1}, 5'b11101);
      tick;
      check("n1_done", done1, 1);
      check("n1_miss_cnt", miss_cnt1, 2);
      check("n1_ones_a", ones_a1, 1);
      check("n1_first_miss", first_miss1, 0);
      tick;
      check("n1_equal", equal1, 0);
      check("n1_done_low", done1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
